// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: next-PC select, PC load enable, D/E stall/flush and imem watchdog.
// Optional PC_FETCH_CTRL_PERF_EN adds saturating stall/redirect performance counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        imem_ready,
  input  logic        load_use_hazard,
  input  logic        branch_taken_d,
  input  logic [31:0] branch_target_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
`ifdef PC_FETCH_CTRL_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redir_cnt,
`endif
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [31:0]     pend_pc_q, pend_pc_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic            redir_s;
  logic [31:0]     redir_tgt_s;
  logic [31:0]     seq_pc_s;
  logic            run_rules_s;

  assign redir_s     = jump_d | branch_taken_d;
  assign redir_tgt_s = jump_d ? jump_target_d : branch_target_d;
  assign seq_pc_s    = pc_f + 32'd4;
  assign fetch_err   = (state_q == S_ERROR);

  // State, pending redirect and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0000_0000;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    wait_cnt_d  = wait_cnt_q;
    pc_next     = seq_pc_s;
    pc_en       = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    run_rules_s = 1'b0;

    case (state_q)
      S_RUN: begin
        run_rules_s = 1'b1;
      end
      S_MEM_WAIT: begin
        if (imem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (pend_q) begin
            pc_en   = 1'b1;
            pc_next = pend_pc_q;
            flush_d = 1'b1;
            pend_d  = 1'b0;
          end else begin
            run_rules_s = 1'b1;
          end
        end else begin
          stall_d = 1'b1;
          flush_e = 1'b1;
          // Only the first redirect seen during a wait is kept
          if (!pend_q && redir_s) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_tgt_s;
          end else begin
            pend_d = pend_q;
          end
          if (wait_cnt_q >= CW'(IMEM_TIMEOUT - 1)) begin
            state_d = S_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
      end
      S_ERROR: begin
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (run_rules_s) begin
      if (load_use_hazard) begin
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (!imem_ready) begin
        stall_d    = 1'b1;
        flush_e    = 1'b1;
        state_d    = S_MEM_WAIT;
        wait_cnt_d = CW'(1);
        if (redir_s) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt_s;
        end else begin
          pend_d = 1'b0;
        end
      end else if (redir_s) begin
        pc_en   = 1'b1;
        pc_next = redir_tgt_s;
        flush_d = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end else begin
      run_rules_s = 1'b0;
    end

    if (rst) begin
      pc_next = RESET_VECTOR;
      pc_en   = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      pc_en = pc_en;
    end
  end

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  assign perf_stall_cnt = perf_stall_q;
  assign perf_redir_cnt = perf_redir_q;

  // Saturating stall-cycle and loaded-redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'h0000_0000;
      perf_redir_q <= 32'h0000_0000;
    end else begin
      if (!pc_en && perf_stall_q != 32'hFFFF_FFFF) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (pc_en && flush_d && perf_redir_q != 32'hFFFF_FFFF) begin
        perf_redir_q <= perf_redir_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table for single-cycle RUN decode,
// hand-written sequences for reset, memory wait, pending redirect and watchdog.
module tb_pc_fetch_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        imem_ready;
  logic        load_use_hazard;
  logic        branch_taken_d;
  logic [31:0] branch_target_d;
  logic        jump_d;
  logic [31:0] jump_target_d;
  logic [31:0] pc_next;
  logic        pc_en, stall_d, flush_d, flush_e, fetch_err;
`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redir_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .IMEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .imem_ready(imem_ready),
    .load_use_hazard(load_use_hazard), .branch_taken_d(branch_taken_d),
    .branch_target_d(branch_target_d), .jump_d(jump_d), .jump_target_d(jump_target_d),
    .pc_next(pc_next), .pc_en(pc_en), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e),
`ifdef PC_FETCH_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_redir_cnt(perf_redir_cnt),
`endif
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic        haz;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] pcf;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_en, e_st, e_fd, e_fe;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic chk_pc, input logic [31:0] e_pc,
                         input logic e_en, input logic e_st, input logic e_fd, input logic e_fe);
    if (chk_pc) chk({name, ".pc_next"}, pc_next, e_pc);
    chk({name, ".pc_en"},   {31'd0, pc_en},   {31'd0, e_en});
    chk({name, ".stall_d"}, {31'd0, stall_d}, {31'd0, e_st});
    chk({name, ".flush_d"}, {31'd0, flush_d}, {31'd0, e_fd});
    chk({name, ".flush_e"}, {31'd0, flush_e}, {31'd0, e_fe});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_use_hazard = 1'b0;
    branch_taken_d  = 1'b0;
    branch_target_d = 32'h0;
    jump_d          = 1'b0;
    jump_target_d   = 32'h0;
    imem_ready      = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // haz br bt j jt pcf chk_pc e_pc en st fd fe
    vecs[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h40,        1'b1, 32'h100,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h40,        1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 32'h80,        1'b1, 32'h400,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'hFFFF_FFFC, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h1234,      1'b1, 32'h1238, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h800, 32'h10,        1'b1, 32'h800,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h900, 32'h20,        1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'hABC0,1'b0, 32'h0,   32'hFFFF_FFFC, 1'b1, 32'hABC0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset for 3 cycles, then sequential fetch with pc_f following pc_next
    pc_f = 32'h0;
    rst  = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out("rst", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    chk("rst.fetch_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk_out("seq", 1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
      pc_f = pc_next;
      tick();
    end

    // Single-cycle RUN decode table
    for (int i = 0; i < 8; i++) begin
      load_use_hazard = vecs[i].haz;
      branch_taken_d  = vecs[i].br;
      branch_target_d = vecs[i].bt;
      jump_d          = vecs[i].j;
      jump_target_d   = vecs[i].jt;
      pc_f            = vecs[i].pcf;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].chk_pc, vecs[i].e_pc,
              vecs[i].e_en, vecs[i].e_st, vecs[i].e_fd, vecs[i].e_fe);
      tick();
    end
    idle();

    // Memory wait with jump in wait cycle 2, later branch ignored, redirect on ready
    pc_f = 32'h50;
    imem_ready = 1'b0;
    #1;
    chk_out("w1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    jump_d = 1'b1; jump_target_d = 32'h200;
    #1;
    chk_out("w2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    jump_d = 1'b0; branch_taken_d = 1'b1; branch_target_d = 32'h300;
    tick();
    idle();
    #1;
    chk_out("wready", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    pc_f = 32'h200;
    #1;
    chk_out("wafter", 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Redirect arriving in the same cycle imem goes not-ready is remembered
    pc_f = 32'h60; imem_ready = 1'b0; branch_taken_d = 1'b1; branch_target_d = 32'h600;
    #1;
    chk_out("rlatch", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    chk_out("rlready", 1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Wait with nothing pending: ready cycle follows normal rules
    pc_f = 32'h70; imem_ready = 1'b0;
    tick();
    imem_ready = 1'b1; branch_taken_d = 1'b1; branch_target_d = 32'h100;
    #1;
    chk_out("nopend", 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();

    // Reset mid-wait drops the pending target
    imem_ready = 1'b0; jump_d = 1'b1; jump_target_d = 32'h700;
    tick();
    do_reset();
    pc_f = 32'h0;
    #1;
    chk_out("rstwait", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Watchdog: TIMEOUT-1 stuck cycles is not yet an error, TIMEOUT is
    pc_f = 32'h80; imem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("wd.before", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("wd.err", {31'd0, fetch_err}, 32'd1);
    imem_ready = 1'b1;
    tick();
    tick();
    chk("wd.sticky", {31'd0, fetch_err}, 32'd1);
    chk_out("wd.hold", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("wd.rstpc", pc_next, 32'h0);
    tick();
    chk("wd.clear", {31'd0, fetch_err}, 32'd0);
    rst = 1'b0;

`ifdef PC_FETCH_CTRL_PERF_EN
    chk("perf.stall0", perf_stall_cnt, 32'd0);
    chk("perf.redir0", perf_redir_cnt, 32'd0);
    pc_f = 32'h40;
    load_use_hazard = 1'b1;
    tick();
    load_use_hazard = 1'b0; branch_taken_d = 1'b1; branch_target_d = 32'h100;
    tick();
    idle();
    tick();
    chk("perf.stall", perf_stall_cnt, 32'd1);
    chk("perf.redir", perf_redir_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
